// File: rtl/mem_pkg.sv
// Shared memory-access definitions: size/sign flags, arbiter state encoding,
// latched request payload and the alignment rule.
package mem_pkg;

    localparam int unsigned XLEN = 64;

    localparam logic [1:0] MEMFLAG_TYPE_BYTE  = 2'b00;
    localparam logic [1:0] MEMFLAG_TYPE_HALF  = 2'b01;
    localparam logic [1:0] MEMFLAG_TYPE_WORD  = 2'b10;
    localparam logic [1:0] MEMFLAG_TYPE_DWORD = 2'b11;
    localparam int unsigned MEMINDEX_UNSIGNED = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Fetches are always unsigned 32-bit words
    localparam logic [2:0] IF_FUNCT3 = 3'b110;

    typedef struct packed {
        logic            owner_if;
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            MEMFLAG_TYPE_BYTE:  mis = 1'b0;
            MEMFLAG_TYPE_HALF:  mis = addr_lo[0];
            MEMFLAG_TYPE_WORD:  mis = |addr_lo[1:0];
            MEMFLAG_TYPE_DWORD: mis = |addr_lo[2:0];
            default:            mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load-data extension: selects size from funct3[1:0] and
// sign- or zero-extends according to the unsigned flag.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] raw,
    output logic [XLEN-1:0] ext_data_c
);

    logic sgn;

    assign sgn = ~funct3[MEMINDEX_UNSIGNED];

    always_comb begin
        ext_data_c = raw;
        case (funct3[1:0])
            MEMFLAG_TYPE_BYTE: ext_data_c = {{56{sgn & raw[7]}},  raw[7:0]};
            MEMFLAG_TYPE_HALF: ext_data_c = {{48{sgn & raw[15]}}, raw[15:0]};
            MEMFLAG_TYPE_WORD: ext_data_c = {{32{sgn & raw[31]}}, raw[31:0]};
            default:           ext_data_c = raw;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between instruction fetch and the
// load/store unit, with alignment checking, load extension and ack timeout.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            if_req_valid,
    output logic            if_req_ready,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_resp_valid,
    output logic [XLEN-1:0] if_resp_data,
    output logic            if_resp_err,

    input  logic            ls_req_valid,
    output logic            ls_req_ready,
    input  logic            ls_we,
    input  logic [2:0]      ls_funct3,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_resp_valid,
    output logic [XLEN-1:0] ls_resp_data,
    output logic            ls_resp_err,

    output logic            mem_req,
    output logic            mem_we,
    output logic [2:0]      mem_funct3,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata
);

    localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SK_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [1:0]      state_q, state_d;
    mem_req_t        req_q, req_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic [SK_W-1:0] streak_q, streak_d;
    logic            mem_req_q, mem_req_d;
    logic            if_resp_valid_q, if_resp_valid_d;
    logic            if_resp_err_q, if_resp_err_d;
    logic [XLEN-1:0] if_resp_data_q, if_resp_data_d;
    logic            ls_resp_valid_q, ls_resp_valid_d;
    logic            ls_resp_err_q, ls_resp_err_d;
    logic [XLEN-1:0] ls_resp_data_q, ls_resp_data_d;

    logic            force_if_c;
    logic            resp_fire_c;
    logic            resp_err_c;
    logic [XLEN-1:0] resp_data_c;
    logic [XLEN-1:0] ext_data_c;

    mem_load_ext u_load_ext (
        .funct3     (req_q.funct3),
        .raw        (mem_rdata),
        .ext_data_c (ext_data_c)
    );

    // LS wins unless it has starved a waiting fetch for STARVE_LIMIT grants
    assign force_if_c   = (streak_q == SK_W'(STARVE_LIMIT)) && if_req_valid && ls_req_valid;
    assign ls_req_ready = (state_q == ST_IDLE) && ls_req_valid && !force_if_c;
    assign if_req_ready = (state_q == ST_IDLE) && if_req_valid && (!ls_req_valid || force_if_c);

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        to_cnt_d    = to_cnt_q;
        streak_d    = streak_q;
        resp_fire_c = 1'b0;
        resp_err_c  = 1'b0;
        resp_data_c = '0;

        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (!if_req_valid) begin
                    streak_d = '0;
                end
                if (ls_req_ready) begin
                    req_d = '{owner_if: 1'b0, we: ls_we, funct3: ls_funct3,
                              addr: ls_addr, wdata: ls_wdata};
                    if (if_req_valid) begin
                        streak_d = streak_q + SK_W'(1);
                    end
                end else if (if_req_ready) begin
                    req_d = '{owner_if: 1'b1, we: 1'b0, funct3: IF_FUNCT3,
                              addr: if_addr, wdata: '0};
                    streak_d = '0;
                end
                if (ls_req_ready || if_req_ready) begin
                    // Misaligned accesses never reach memory
                    if (is_misaligned(req_d.funct3, req_d.addr[2:0])) begin
                        state_d     = ST_RESP;
                        resp_fire_c = 1'b1;
                        resp_err_c  = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (mem_ack) begin
                    state_d     = ST_RESP;
                    resp_fire_c = 1'b1;
                    resp_data_c = req_q.we ? '0 : ext_data_c;
                end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d     = ST_RESP;
                    resp_fire_c = 1'b1;
                    resp_err_c  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_req_d       = (state_d == ST_BUSY);
        if_resp_valid_d = resp_fire_c && req_d.owner_if;
        if_resp_err_d   = resp_fire_c && req_d.owner_if && resp_err_c;
        if_resp_data_d  = (resp_fire_c && req_d.owner_if) ? resp_data_c : '0;
        ls_resp_valid_d = resp_fire_c && !req_d.owner_if;
        ls_resp_err_d   = resp_fire_c && !req_d.owner_if && resp_err_c;
        ls_resp_data_d  = (resp_fire_c && !req_d.owner_if) ? resp_data_c : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            req_q           <= '0;
            to_cnt_q        <= '0;
            streak_q        <= '0;
            mem_req_q       <= 1'b0;
            if_resp_valid_q <= 1'b0;
            if_resp_err_q   <= 1'b0;
            if_resp_data_q  <= '0;
            ls_resp_valid_q <= 1'b0;
            ls_resp_err_q   <= 1'b0;
            ls_resp_data_q  <= '0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            to_cnt_q        <= to_cnt_d;
            streak_q        <= streak_d;
            mem_req_q       <= mem_req_d;
            if_resp_valid_q <= if_resp_valid_d;
            if_resp_err_q   <= if_resp_err_d;
            if_resp_data_q  <= if_resp_data_d;
            ls_resp_valid_q <= ls_resp_valid_d;
            ls_resp_err_q   <= ls_resp_err_d;
            ls_resp_data_q  <= ls_resp_data_d;
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = req_q.we;
    assign mem_funct3    = req_q.funct3;
    assign mem_addr      = req_q.addr;
    assign mem_wdata     = req_q.wdata;
    assign if_resp_valid = if_resp_valid_q;
    assign if_resp_err   = if_resp_err_q;
    assign if_resp_data  = if_resp_data_q;
    assign ls_resp_valid = ls_resp_valid_q;
    assign ls_resp_err   = ls_resp_err_q;
    assign ls_resp_data  = ls_resp_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed requests, an expected
// response/memory-window model, and a per-cycle compare process.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;
    localparam int STARVE  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid, if_req_ready;
    logic [63:0] if_addr;
    logic        if_resp_valid, if_resp_err;
    logic [63:0] if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_we;
    logic [2:0]  ls_funct3;
    logic [63:0] ls_addr, ls_wdata;
    logic        ls_resp_valid, ls_resp_err;
    logic [63:0] ls_resp_data;
    logic        mem_req, mem_we, mem_ack;
    logic [2:0]  mem_funct3;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_LIMIT(STARVE)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data), .if_resp_err(if_resp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
        .ls_funct3(ls_funct3), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data), .ls_resp_err(ls_resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        bit          is_if;
        logic [63:0] data;
        bit          err;
        int          at;
    } resp_t;

    typedef struct {
        int          from;
        int          to;
        logic [63:0] addr;
        logic        we;
        logic [2:0]  f3;
        logic [63:0] wdata;
    } win_t;

    resp_t rq[$];
    win_t  wq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Extension rule from size/sign, computed arithmetically
    function automatic logic [63:0] model_ext(input logic [2:0] f3, input logic [63:0] raw);
        int          bits;
        logic [63:0] mask, v;
        bits = 8 << f3[1:0];
        mask = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        v = raw & mask;
        if (!f3[2] && bits < 64 && ((v >> (bits - 1)) & 64'd1) == 64'd1) v = v | ~mask;
        return v;
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [63:0] addr);
        int nbytes;
        nbytes = 1 << f3[1:0];
        return (addr & 64'(nbytes - 1)) != 64'd0;
    endfunction

    // Per-cycle compare against the expected memory windows and responses
    bit    exp_mreq, exp_ifv, exp_lsv, exp_err;
    logic [63:0] exp_data;
    resp_t er;
    always @(negedge clk) begin
        if (chk_en) begin
            while (wq.size() > 0 && wq[0].to < cyc) wq.delete(0);
            exp_mreq = (wq.size() > 0) && (wq[0].from <= cyc);
            check("mem_req", 64'(mem_req), 64'(exp_mreq));
            if (exp_mreq) begin
                check("mem_addr", mem_addr, wq[0].addr);
                check("mem_we", 64'(mem_we), 64'(wq[0].we));
                check("mem_funct3", 64'(mem_funct3), 64'(wq[0].f3));
                if (wq[0].we) check("mem_wdata", mem_wdata, wq[0].wdata);
            end
            exp_ifv = 1'b0; exp_lsv = 1'b0; exp_err = 1'b0; exp_data = '0;
            if (rq.size() > 0 && rq[0].at == cyc) begin
                er = rq.pop_front();
                exp_ifv  = er.is_if;
                exp_lsv  = !er.is_if;
                exp_data = er.data;
                exp_err  = er.err;
            end
            check("if_resp_valid", 64'(if_resp_valid), 64'(exp_ifv));
            check("ls_resp_valid", 64'(ls_resp_valid), 64'(exp_lsv));
            if (exp_ifv) begin
                check("if_resp_data", if_resp_data, exp_data);
                check("if_resp_err", 64'(if_resp_err), 64'(exp_err));
            end
            if (exp_lsv) begin
                check("ls_resp_data", ls_resp_data, exp_data);
                check("ls_resp_err", 64'(ls_resp_err), 64'(exp_err));
            end
        end
    end

    // One request from IDLE; k = BUSY cycle carrying the ack (0 = never ack)
    task automatic do_req(input bit is_if, input bit we, input logic [2:0] f3,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] raw, input int k,
                          input bit has_lit, input logic [63:0] lit, input bit lit_err);
        int         a, rc;
        bit         mis, acked;
        logic [2:0] ef3;
        resp_t      r;
        win_t       w;
        @(posedge clk); #1;
        ef3 = is_if ? 3'b110 : f3;
        if (is_if) begin
            if_req_valid = 1'b1; if_addr = addr;
        end else begin
            ls_req_valid = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr; ls_wdata = wdata;
        end
        a     = cyc + 1;
        mis   = model_mis(ef3, addr);
        acked = (k >= 1) && (k <= TIMEOUT);
        rc    = mis ? a : (acked ? a + k : a + TIMEOUT);
        if (!mis) begin
            w.from = a; w.to = rc - 1; w.addr = addr; w.we = is_if ? 1'b0 : we;
            w.f3 = ef3; w.wdata = wdata;
            wq.push_back(w);
        end
        r.is_if = is_if;
        r.err   = mis || !acked;
        r.data  = (r.err || (we && !is_if)) ? 64'd0 : model_ext(ef3, raw);
        r.at    = rc;
        rq.push_back(r);
        @(negedge clk);
        check("if_req_ready", 64'(if_req_ready), 64'(is_if));
        check("ls_req_ready", 64'(ls_req_ready), 64'(!is_if));
        @(posedge clk); #1;
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        if_addr = 64'hDEAD_0000_0000_0007; ls_addr = 64'hBEEF_0000_0000_0005;
        ls_funct3 = 3'b111; ls_we = ~we; ls_wdata = ~wdata;
        while (cyc < rc) begin
            if (!mis && acked && cyc == a + k - 1) begin
                mem_ack = 1'b1; mem_rdata = raw;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        @(negedge clk);
        if (has_lit) begin
            check("lit_data", is_if ? if_resp_data : ls_resp_data, lit);
            check("lit_err", 64'(is_if ? if_resp_err : ls_resp_err), 64'(lit_err));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int          a;
    bit          g_if;
    win_t        w0;
    resp_t       r0;
    logic [63:0] rdat;

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b0; if_addr = '0;
        ls_req_valid = 1'b0; ls_we = 1'b0; ls_funct3 = '0; ls_addr = '0; ls_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_funct3", 64'(mem_funct3), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_if_resp_valid", 64'(if_resp_valid), 64'd0);
        check("rst_ls_resp_valid", 64'(ls_resp_valid), 64'd0);
        check("rst_if_resp_data", if_resp_data, 64'd0);
        check("rst_ls_resp_data", ls_resp_data, 64'd0);
        check("rst_resp_err", 64'({if_resp_err, ls_resp_err}), 64'd0);
        chk_en = 1'b1;

        // Loads with extension, store, fetch
        do_req(0, 0, 3'b000, 64'h1003, 0, 64'h80, 3, 1, 64'hFFFF_FFFF_FFFF_FF80, 0);
        do_req(0, 0, 3'b100, 64'h1003, 0, 64'h80, 3, 1, 64'h0000_0000_0000_0080, 0);
        do_req(0, 0, 3'b001, 64'h2006, 0, 64'h1234_8001, 2, 1, 64'hFFFF_FFFF_FFFF_8001, 0);
        do_req(0, 0, 3'b110, 64'h3004, 0, 64'hAAAA_BBBB_F000_0001, 1, 1, 64'h0000_0000_F000_0001, 0);
        do_req(0, 1, 3'b011, 64'h4008, 64'h0123_4567_89AB_CDEF, 64'h5555, 2, 1, 64'd0, 0);
        do_req(1, 0, 3'b000, 64'h1000, 0, 64'hFFFF_FFFF_8000_0013, 1, 1, 64'h0000_0000_8000_0013, 0);

        // Misaligned store and fetch
        do_req(0, 1, 3'b010, 64'h2002, 64'h77, 0, 1, 1, 64'd0, 1);
        do_req(1, 0, 3'b000, 64'h1001, 0, 0, 1, 1, 64'd0, 1);

        // Timeout, then ack in the last allowed cycle
        do_req(0, 0, 3'b011, 64'h6000, 0, 64'h99, 0, 1, 64'd0, 1);
        do_req(0, 0, 3'b011, 64'h6008, 0, 64'h55, 16, 1, 64'h55, 0);

        // Reset in the second BUSY cycle
        @(posedge clk); #1;
        ls_req_valid = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b011; ls_addr = 64'h5000;
        a = cyc + 1;
        w0.from = a; w0.to = a + 1; w0.addr = 64'h5000; w0.we = 1'b0; w0.f3 = 3'b011; w0.wdata = '0;
        wq.push_back(w0);
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_mem_req", 64'(mem_req), 64'd0);
        check("rstmid_mem_addr", mem_addr, 64'd0);
        check("rstmid_resp_valid", 64'({if_resp_valid, ls_resp_valid}), 64'd0);

        // Zero-wait dword load passes data through
        do_req(0, 0, 3'b011, 64'h40, 0, 64'h8000_0000_0000_0001, 1, 1, 64'h8000_0000_0000_0001, 0);

        // Ack while idle is ignored
        @(posedge clk); #1; mem_ack = 1'b1; mem_rdata = 64'h1234;
        @(posedge clk); #1; mem_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Both requesters valid, ack held: LS x4, IF, LS
        rdat = 64'hDEAD_BEEF_8765_4321;
        @(posedge clk); #1;
        mem_ack = 1'b1; mem_rdata = rdat;
        if_req_valid = 1'b1; if_addr = 64'h8000;
        ls_req_valid = 1'b1; ls_we = 1'b0; ls_funct3 = 3'b011; ls_addr = 64'h9000; ls_wdata = '0;
        for (int i = 0; i < 6; i++) begin
            g_if = (i == 4);
            a = cyc + 1;
            w0.from = a; w0.to = a; w0.addr = g_if ? 64'h8000 : 64'h9000; w0.we = 1'b0;
            w0.f3 = g_if ? 3'b110 : 3'b011; w0.wdata = '0;
            wq.push_back(w0);
            r0.is_if = g_if; r0.err = 1'b0; r0.at = a + 1;
            r0.data = model_ext(g_if ? 3'b110 : 3'b011, rdat);
            rq.push_back(r0);
            @(negedge clk);
            check("starve_if_ready", 64'(if_req_ready), 64'(g_if));
            check("starve_ls_ready", 64'(ls_req_ready), 64'(!g_if));
            @(posedge clk); #1;
            if (i == 5) begin
                if_req_valid = 1'b0; ls_req_valid = 1'b0;
            end
            @(posedge clk); #1;
            @(negedge clk);
            if (g_if) check("starve_if_data", if_resp_data, 64'h0000_0000_8765_4321);
            if (i < 5) begin
                @(posedge clk); #1;
            end
        end
        mem_ack = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-memory port between two requesters: instruction fetch (port IF, read-only) and load/store unit (port LS).
- Sequences each access with a request/ack handshake and enforces alignment.
- Applies funct3-based sign or zero extension to read data.
- Times out accesses the memory never acknowledges.
- Sits between the core pipeline and the memory block.

Parameters:
- TIMEOUT, 16, cycles in BUSY without mem_ack before an error response is returned (minimum 2).
- STARVE_LIMIT, 4, consecutive LS grants while IF is waiting, after which IF is forced to win.

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous active-high reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  64  fetch address; implied funct3 = 3'b110 (word, unsigned)
- if_resp_valid  out  1  one-cycle response pulse to fetch
- if_resp_data  out  64  zero-extended instruction word
- if_resp_err  out  1  misaligned or timeout
- ls_req_valid  in  1  load/store request
- ls_req_ready  out  1  load/store request accepted this cycle
- ls_we  in  1  1 = store
- ls_funct3  in  3  [1:0] size (byte/half/word/dword), [2] unsigned
- ls_addr  in  64  effective address
- ls_wdata  in  64  store data, low bytes used per size
- ls_resp_valid  out  1  one-cycle response pulse to LS
- ls_resp_data  out  64  extended load data; 0 for stores
- ls_resp_err  out  1  misaligned or timeout
- mem_req  out  1  memory access request, held until ack
- mem_we  out  1  write enable
- mem_funct3  out  3  access size/sign, passed through
- mem_addr  out  64  address
- mem_wdata  out  64  write data
- mem_ack  in  1  memory completed access this cycle
- mem_rdata  in  64  raw read data, zero-extended, valid with mem_ack

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE; streak and timeout counters clear.
  - All outputs are 0 after the edge, including mem_req.
  - Reset mid-access drops mem_req and emits no response.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - The winner's req_ready is combinationally 1; the loser's req_ready is 0.
  - A request is accepted when valid&&ready at posedge. Its addr/we/funct3/wdata and owner are latched.
  - Aligned request: go to BUSY.
  - Misaligned request: go to RESP with err=1; mem_req is never raised.
  - Misaligned means: half with addr[0]≠0; word with addr[1:0]≠0; dword with addr[2:0]≠0.
- Arbitration:
  - LS has priority.
  - Streak counter increments on each LS grant while if_req_valid=1. It clears on an IF grant, or whenever if_req_valid=0 in IDLE.
  - When streak == STARVE_LIMIT and both requesters are valid, IF wins.
- BUSY:
  - mem_req=1; mem_* outputs are driven from latched registers and stay stable until ack.
  - Timeout counter increments each BUSY cycle.
  - On mem_ack: capture data, then go to RESP with err=0.
    - Reads: data is extended per latched funct3 (unsigned bit set → zero-extend; else sign-extend from bit 7/15/31; dword passes through).
    - Writes: data = 0.
  - Timeout counter reaches TIMEOUT-1 without ack: go to RESP with err=1, data=0.
  - mem_ack and timeout in the same cycle: ack wins.
- RESP:
  - The owner's resp_valid=1 for exactly one cycle, with data/err. The other port's resp_valid=0.
  - Next state is IDLE; no request is accepted in this cycle.
- Latency:
  - Zero-wait memory (ack in the first BUSY cycle): resp_valid rises 2 cycles after the accept edge.
  - Misaligned request: resp_valid rises 1 cycle after the accept edge.
  - Back-to-back throughput is one access per 3 cycles.
- mem_ack outside BUSY is ignored.
- Requesters may drop valid before acceptance; after acceptance, changes to their inputs have no effect.

Decomposition:
- Shared package (mem_pkg) holds:
  - MEMFLAG_TYPE_BYTE/HALF/WORD/DWORD (2'b00..2'b11) and MEMINDEX_UNSIGNED (=2).
  - The FSM state encoding and the IF fixed funct3 constant.
- Natural sub-module: mem_load_ext. It is purely combinational: funct3 + raw 64-bit data → extended 64-bit data. It is reusable by the memory block itself.

Test Plan:
- LS load byte, funct3=3'b000, addr 0x1003, mem_rdata=0x80 with ack in the 3rd BUSY cycle → ls_resp_valid one cycle, data 0xFFFF_FFFF_FFFF_FF80, err=0; with funct3=3'b100 → data 0x80.
- Both valid continuously, STARVE_LIMIT=4 → grant order LS, LS, LS, LS, IF, then LS again; if_resp_data = ack'd word zero-extended.
- LS word store addr 0x2002 → no mem_req, ls_resp_valid 1 cycle after accept, err=1; fetch addr 0x1001 → if_resp_err=1.
- mem_ack held 0, TIMEOUT=16 → mem_req high exactly 16 cycles, then resp err=1, data=0; ack arriving in the 16th cycle instead → err=0.
- rst asserted in the 2nd BUSY cycle → mem_req=0 and all resp_valid=0 after the edge; next request completes normally.
- Zero-wait memory, LS dword load 0x8000_0000_0000_0001 → resp 2 cycles after accept, data unchanged; ack pulsed while IDLE → no response.
